// File: rtl/hbm_stride_reader.sv
// hbm_stride_reader: AXI4 read master for one HBM pseudo-channel.
// Issues read_ops equally spaced bursts with bounded outstanding and streams the beats downstream.
module hbm_stride_reader #(
    parameter int ENGINE_ID       = 0,
    parameter int ADDR_WIDTH      = 33,
    parameter int DATA_WIDTH      = 256,
    parameter int ID_WIDTH        = 5,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_read,
    input  logic [31:0]           read_ops,
    input  logic [31:0]           stride,
    input  logic [ADDR_WIDTH-1:0] init_addr,
    input  logic [15:0]           mem_burst_size,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  m_axi_ARVALID,
    output logic [ADDR_WIDTH-1:0] m_axi_ARADDR,
    output logic [ID_WIDTH-1:0]   m_axi_ARID,
    output logic [7:0]            m_axi_ARLEN,
    output logic [2:0]            m_axi_ARSIZE,
    output logic [1:0]            m_axi_ARBURST,
    output logic [1:0]            m_axi_ARLOCK,
    output logic [3:0]            m_axi_ARCACHE,
    output logic [2:0]            m_axi_ARPROT,
    output logic [3:0]            m_axi_ARQOS,
    output logic [3:0]            m_axi_ARREGION,
    input  logic                  m_axi_ARREADY,
    input  logic                  m_axi_RVALID,
    input  logic [DATA_WIDTH-1:0] m_axi_RDATA,
    input  logic                  m_axi_RLAST,
    input  logic [ID_WIDTH-1:0]   m_axi_RID,
    input  logic [1:0]            m_axi_RRESP,
    output logic                  m_axi_RREADY,
    output logic                  dn_vld,
    output logic [DATA_WIDTH-1:0] dn_dat,
    output logic                  dn_last,
    input  logic                  dn_rdy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } state_e;

    localparam int         BEAT_BYTES = DATA_WIDTH / 8;
    localparam logic [2:0] AR_SIZE    = (DATA_WIDTH == 512) ? 3'b110 : 3'b101;
    localparam logic [3:0] PC_SEL     = 4'(ENGINE_ID);
    localparam logic [7:0] MAX_OUT    = 8'(MAX_OUTSTANDING);

    state_e                state_q, state_d;
    logic [31:0]           ops_q, ops_d;
    logic [27:0]           stride_q, stride_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [7:0]            arlen_q, arlen_d;
    logic [31:0]           issued_q, issued_d;
    logic [7:0]            outst_q, outst_d;
    logic                  arvalid_q, arvalid_d;
    logic                  err_q, err_d;
    logic                  done_q, done_d;

    logic                  ar_hs;
    logic                  r_hs;
    logic                  outst_dec;
    logic                  last_issue;
    logic [15:0]           beats;
    logic [7:0]            len_calc;
    logic                  unused_inputs;

    // The pseudo-channel select replaces the upper offset bits, and the slave's RID is not checked.
    assign unused_inputs = ^{init_addr[ADDR_WIDTH-1:28], stride[31:28], m_axi_RID};

    assign ar_hs      = arvalid_q && m_axi_ARREADY;
    assign r_hs       = m_axi_RVALID && dn_rdy;
    assign outst_dec  = r_hs && m_axi_RLAST && (outst_q != 8'd0);
    assign last_issue = ar_hs && (issued_q == ops_q - 32'd1);

    assign dn_vld       = m_axi_RVALID;
    assign dn_dat       = m_axi_RDATA;
    assign dn_last      = m_axi_RLAST;
    assign m_axi_RREADY = dn_rdy;

    // Beats per burst, clamped to what a single AXI4 INCR burst can carry.
    always_comb begin
        beats = mem_burst_size / 16'(BEAT_BYTES);
        if (beats == 16'd0) begin
            len_calc = 8'd0;
        end else if (beats >= 16'd256) begin
            len_calc = 8'hFF;
        end else begin
            len_calc = beats[7:0] - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ops_q     <= '0;
            stride_q  <= '0;
            araddr_q  <= '0;
            arlen_q   <= '0;
            issued_q  <= '0;
            outst_q   <= '0;
            arvalid_q <= 1'b0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ops_q     <= ops_d;
            stride_q  <= stride_d;
            araddr_q  <= araddr_d;
            arlen_q   <= arlen_d;
            issued_q  <= issued_d;
            outst_q   <= outst_d;
            arvalid_q <= arvalid_d;
            err_q     <= err_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ops_d     = ops_q;
        stride_d  = stride_q;
        araddr_d  = araddr_q;
        arlen_d   = arlen_q;
        issued_d  = issued_q;
        outst_d   = outst_q;
        arvalid_d = arvalid_q;
        err_d     = err_q;
        done_d    = 1'b0;

        if (ar_hs && !outst_dec) begin
            outst_d = outst_q + 8'd1;
        end else if (!ar_hs && outst_dec) begin
            outst_d = outst_q - 8'd1;
        end

        if (r_hs && ((m_axi_RRESP != 2'b00) || (m_axi_RLAST && (outst_q == 8'd0)))) begin
            err_d = 1'b1;
        end

        // The offset wraps inside 28 bits so it never disturbs the pseudo-channel select.
        if (ar_hs) begin
            issued_d        = issued_q + 32'd1;
            araddr_d[27:0]  = araddr_q[27:0] + stride_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_read) begin
                    ops_d           = read_ops;
                    stride_d        = stride[27:0];
                    arlen_d         = len_calc;
                    araddr_d        = '0;
                    araddr_d[31:28] = PC_SEL;
                    araddr_d[27:0]  = init_addr[27:0];
                    issued_d        = '0;
                    outst_d         = '0;
                    err_d           = 1'b0;
                    if (read_ops == 32'd0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d   = ST_ISSUE;
                        arvalid_d = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                if (last_issue) begin
                    arvalid_d = 1'b0;
                    state_d   = ST_DRAIN;
                end else if (!arvalid_q || ar_hs) begin
                    arvalid_d = (outst_d < MAX_OUT);
                end
            end
            ST_DRAIN: begin
                if (outst_q == 8'd0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        busy           = (state_q != ST_IDLE) && (state_q != ST_DONE);
        done           = done_q;
        err            = err_q;
        m_axi_ARVALID  = arvalid_q;
        m_axi_ARADDR   = araddr_q;
        m_axi_ARLEN    = arlen_q;
        m_axi_ARID     = '0;
        m_axi_ARSIZE   = AR_SIZE;
        m_axi_ARBURST  = 2'b01;
        m_axi_ARLOCK   = 2'b00;
        m_axi_ARCACHE  = 4'b0000;
        m_axi_ARPROT   = 3'b010;
        m_axi_ARQOS    = 4'd0;
        m_axi_ARREGION = 4'd0;
    end

endmodule

// File: tb/tb_hbm_stride_reader.sv
// tb_hbm_stride_reader: drives hbm_stride_reader with a behavioural AXI slave and compares
// the observed addresses, beats and status against a queue-based reference of the read job.
module tb_hbm_stride_reader;

    localparam int ENGINE_ID  = 5;
    localparam int ADDR_WIDTH = 33;
    localparam int DATA_WIDTH = 256;
    localparam int ID_WIDTH   = 5;
    localparam int MAX_OUT    = 2;
    localparam int BEAT_BYTES = DATA_WIDTH / 8;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  start_read = 1'b0;
    logic [31:0]           read_ops = '0;
    logic [31:0]           stride = '0;
    logic [ADDR_WIDTH-1:0] init_addr = '0;
    logic [15:0]           mem_burst_size = '0;
    logic                  busy, done, err;
    logic                  m_axi_ARVALID;
    logic [ADDR_WIDTH-1:0] m_axi_ARADDR;
    logic [ID_WIDTH-1:0]   m_axi_ARID;
    logic [7:0]            m_axi_ARLEN;
    logic [2:0]            m_axi_ARSIZE;
    logic [1:0]            m_axi_ARBURST;
    logic [1:0]            m_axi_ARLOCK;
    logic [3:0]            m_axi_ARCACHE;
    logic [2:0]            m_axi_ARPROT;
    logic [3:0]            m_axi_ARQOS;
    logic [3:0]            m_axi_ARREGION;
    logic                  m_axi_ARREADY = 1'b0;
    logic                  m_axi_RVALID = 1'b0;
    logic [DATA_WIDTH-1:0] m_axi_RDATA = '0;
    logic                  m_axi_RLAST = 1'b0;
    logic [ID_WIDTH-1:0]   m_axi_RID = '0;
    logic [1:0]            m_axi_RRESP = '0;
    logic                  m_axi_RREADY;
    logic                  dn_vld;
    logic [DATA_WIDTH-1:0] dn_dat;
    logic                  dn_last;
    logic                  dn_rdy = 1'b0;

    always #5 clk = ~clk;

    hbm_stride_reader #(
        .ENGINE_ID      (ENGINE_ID),
        .ADDR_WIDTH     (ADDR_WIDTH),
        .DATA_WIDTH     (DATA_WIDTH),
        .ID_WIDTH       (ID_WIDTH),
        .MAX_OUTSTANDING(MAX_OUT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_read    (start_read),
        .read_ops      (read_ops),
        .stride        (stride),
        .init_addr     (init_addr),
        .mem_burst_size(mem_burst_size),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .m_axi_ARVALID (m_axi_ARVALID),
        .m_axi_ARADDR  (m_axi_ARADDR),
        .m_axi_ARID    (m_axi_ARID),
        .m_axi_ARLEN   (m_axi_ARLEN),
        .m_axi_ARSIZE  (m_axi_ARSIZE),
        .m_axi_ARBURST (m_axi_ARBURST),
        .m_axi_ARLOCK  (m_axi_ARLOCK),
        .m_axi_ARCACHE (m_axi_ARCACHE),
        .m_axi_ARPROT  (m_axi_ARPROT),
        .m_axi_ARQOS   (m_axi_ARQOS),
        .m_axi_ARREGION(m_axi_ARREGION),
        .m_axi_ARREADY (m_axi_ARREADY),
        .m_axi_RVALID  (m_axi_RVALID),
        .m_axi_RDATA   (m_axi_RDATA),
        .m_axi_RLAST   (m_axi_RLAST),
        .m_axi_RID     (m_axi_RID),
        .m_axi_RRESP   (m_axi_RRESP),
        .m_axi_RREADY  (m_axi_RREADY),
        .dn_vld        (dn_vld),
        .dn_dat        (dn_dat),
        .dn_last       (dn_last),
        .dn_rdy        (dn_rdy)
    );

    typedef struct {
        int k;
        int beats;
        int ready;
    } burst_t;

    int n_asserts = 0;
    int n_fail    = 0;

    int          r_delay = 0;
    int          rdy_mode = 0;
    int          stall_left = 0;
    int          err_burst = -1;
    logic [31:0] salt = 32'h0;

    logic [ADDR_WIDTH-1:0] ar_addr_log[$];
    logic [7:0]            ar_len_log[$];
    logic [DATA_WIDTH-1:0] dn_dat_log[$];
    logic                  dn_last_log[$];
    burst_t                pend[$];

    int cycle = 0;
    int outst = 0;
    int beat_idx = 0;
    int ar_count = 0;
    int done_count = 0;
    int done_cycle = -1;
    int last_rlast_cycle = -1;
    int start_cycle = 0;
    int max_outst = 0;
    int limit_viol = 0;
    int stall_viol = 0;
    int mirror_viol = 0;

    logic                  cap_ar_hs = 1'b0;
    logic                  cap_arvalid = 1'b0;
    logic [ADDR_WIDTH-1:0] cap_araddr = '0;
    logic [7:0]            cap_arlen = '0;
    logic                  cap_r_hs = 1'b0;
    logic                  cap_rlast = 1'b0;
    logic [DATA_WIDTH-1:0] cap_rdata = '0;

    function automatic logic [DATA_WIDTH-1:0] beat_pattern(input int k, input int j);
        logic [31:0] w;
        w = salt ^ (32'(k) << 16) ^ 32'(j);
        return {8{w}};
    endfunction

    // Behavioural AXI slave: drives on the falling edge, then records what the next rising edge will see.
    always @(negedge clk) begin
        cycle++;
        if (!rst_n) begin
            pend.delete();
            beat_idx      = 0;
            outst         = 0;
            m_axi_ARREADY = 1'b0;
            m_axi_RVALID  = 1'b0;
            m_axi_RLAST   = 1'b0;
            m_axi_RDATA   = '0;
            m_axi_RRESP   = 2'b00;
            dn_rdy        = 1'b0;
            cap_ar_hs     = 1'b0;
            cap_arvalid   = 1'b0;
            cap_r_hs      = 1'b0;
        end else begin
            if (cap_ar_hs) begin
                ar_addr_log.push_back(cap_araddr);
                ar_len_log.push_back(cap_arlen);
                pend.push_back('{ar_count, int'(cap_arlen) + 1, cycle + r_delay});
                ar_count++;
                outst++;
            end
            if (cap_r_hs) begin
                dn_dat_log.push_back(cap_rdata);
                dn_last_log.push_back(cap_rlast);
                if (cap_rlast) begin
                    if (pend.size() > 0) pend.pop_front();
                    beat_idx = 0;
                    outst--;
                    last_rlast_cycle = cycle;
                end else begin
                    beat_idx++;
                end
            end
            if (outst > max_outst) max_outst = outst;
            m_axi_ARREADY = (stall_left == 0);
            if (pend.size() > 0 && pend[0].ready <= cycle) begin
                m_axi_RVALID = 1'b1;
                m_axi_RDATA  = beat_pattern(pend[0].k, beat_idx);
                m_axi_RLAST  = (beat_idx == pend[0].beats - 1);
                m_axi_RRESP  = (pend[0].k == err_burst) ? 2'b10 : 2'b00;
            end else begin
                m_axi_RVALID = 1'b0;
                m_axi_RLAST  = 1'b0;
                m_axi_RRESP  = 2'b00;
            end
            case (rdy_mode)
                0:       dn_rdy = 1'b1;
                1:       dn_rdy = ~dn_rdy;
                default: dn_rdy = 1'($urandom_range(0, 1));
            endcase
        end
        #1;
        if (rst_n) begin
            if (cap_arvalid && !cap_ar_hs &&
                !(m_axi_ARVALID === 1'b1 && m_axi_ARADDR === cap_araddr && m_axi_ARLEN === cap_arlen))
                stall_viol++;
            if (m_axi_ARVALID && outst >= MAX_OUT) limit_viol++;
            if (m_axi_RREADY !== dn_rdy || dn_vld !== m_axi_RVALID ||
                dn_dat !== m_axi_RDATA || dn_last !== m_axi_RLAST)
                mirror_viol++;
            if (m_axi_ARVALID && !m_axi_ARREADY && stall_left > 0) stall_left--;
            if (done) begin
                done_count++;
                done_cycle = cycle;
            end
        end
        cap_ar_hs   = rst_n && m_axi_ARVALID && m_axi_ARREADY;
        cap_arvalid = rst_n && m_axi_ARVALID;
        cap_araddr  = m_axi_ARADDR;
        cap_arlen   = m_axi_ARLEN;
        cap_r_hs    = rst_n && m_axi_RVALID && m_axi_RREADY;
        cap_rlast   = m_axi_RLAST;
        cap_rdata   = m_axi_RDATA;
    end

    task automatic check_output(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [31:0] ops, input logic [31:0] str,
                                  input logic [ADDR_WIDTH-1:0] base, input logic [15:0] size,
                                  input int delay, input int rmode, input int stall,
                                  input int eburst, input bit poke);
        @(negedge clk);
        #2;
        ar_addr_log.delete();
        ar_len_log.delete();
        dn_dat_log.delete();
        dn_last_log.delete();
        ar_count         = 0;
        done_count       = 0;
        done_cycle       = -1;
        last_rlast_cycle = -1;
        max_outst        = 0;
        limit_viol       = 0;
        stall_viol       = 0;
        mirror_viol      = 0;
        r_delay          = delay;
        rdy_mode         = rmode;
        stall_left       = stall;
        err_burst        = eburst;
        salt             = $urandom;
        read_ops         = ops;
        stride           = str;
        init_addr        = base;
        mem_burst_size   = size;
        start_read       = 1'b1;
        start_cycle      = cycle;
        @(negedge clk);
        #2;
        start_read = 1'b0;
        check_output("busy_after_start", busy, ops != 32'd0);
        if (poke) begin
            repeat (4) @(negedge clk);
            #2;
            read_ops   = 32'd1;
            stride     = 32'd0;
            start_read = 1'b1;
            @(negedge clk);
            #2;
            start_read = 1'b0;
        end
        for (int i = 0; i < 20000 && done_count == 0; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        #2;
    endtask

    // Reference model: addresses from base + k*stride mod 2^28, beats from the clamped burst size.
    task automatic check_run(input string tag, input logic [31:0] ops, input logic [31:0] str,
                             input logic [ADDR_WIDTH-1:0] base, input logic [15:0] size,
                             input logic err_exp);
        int b;
        int idx;
        int errs;
        int lasts;
        logic [ADDR_WIDTH-1:0] ea;
        b = int'(size) / BEAT_BYTES;
        if (b < 1) b = 1;
        if (b > 256) b = 256;
        check_output({tag, " ar_count"}, ar_addr_log.size(), ops);
        for (int k = 0; k < int'(ops) && k < ar_addr_log.size(); k++) begin
            ea        = '0;
            ea[31:28] = 4'(ENGINE_ID);
            ea[27:0]  = 28'(longint'(base[27:0]) + longint'(k) * longint'(str));
            check_output($sformatf("%s araddr[%0d]", tag, k), ar_addr_log[k], ea);
            check_output($sformatf("%s arlen[%0d]", tag, k), ar_len_log[k], b - 1);
        end
        check_output({tag, " beat_count"}, dn_dat_log.size(), int'(ops) * b);
        idx   = 0;
        errs  = 0;
        lasts = 0;
        for (int k = 0; k < int'(ops); k++) begin
            for (int j = 0; j < b; j++) begin
                if (idx < dn_dat_log.size()) begin
                    if (dn_dat_log[idx] !== beat_pattern(k, j) || dn_last_log[idx] !== (j == b - 1))
                        errs++;
                    if (dn_last_log[idx]) lasts++;
                end
                idx++;
            end
        end
        check_output({tag, " payload_errors"}, errs, 0);
        check_output({tag, " last_count"}, lasts, ops);
        check_output({tag, " done_pulses"}, done_count, 1);
        if (ops == 32'd0)
            check_output({tag, " done_cycle"}, done_cycle, start_cycle + 2);
        else
            check_output({tag, " done_after_rlast"}, done_cycle, last_rlast_cycle + 2);
        check_output({tag, " max_outstanding_ok"}, max_outst <= MAX_OUT, 1'b1);
        check_output({tag, " arvalid_at_limit"}, limit_viol, 0);
        check_output({tag, " ar_stability"}, stall_viol, 0);
        check_output({tag, " r_passthrough"}, mirror_viol, 0);
        check_output({tag, " err"}, err, err_exp);
        check_output({tag, " busy_idle"}, busy, 1'b0);
    endtask

    initial begin
        logic [31:0] r_ops;
        logic [31:0] r_str;
        logic [ADDR_WIDTH-1:0] r_base;
        logic [15:0] r_size;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        check_output("rst arvalid", m_axi_ARVALID, 1'b0);
        check_output("rst araddr", m_axi_ARADDR, '0);
        check_output("rst busy", busy, 1'b0);
        check_output("rst done", done, 1'b0);
        check_output("rst err", err, 1'b0);
        check_output("arid", m_axi_ARID, '0);
        check_output("arsize", m_axi_ARSIZE, 3'b101);
        check_output("arburst", m_axi_ARBURST, 2'b01);
        check_output("arlock", m_axi_ARLOCK, 2'b00);
        check_output("arcache", m_axi_ARCACHE, 4'b0000);
        check_output("arprot", m_axi_ARPROT, 3'b010);
        check_output("arqos", m_axi_ARQOS, 4'd0);
        check_output("arregion", m_axi_ARREGION, 4'd0);
        rst_n = 1'b1;

        apply_stimulus(32'd4, 32'h1000, 33'h100, 16'd1024, 1, 0, 0, -1, 1'b0);
        check_run("basic", 32'd4, 32'h1000, 33'h100, 16'd1024, 1'b0);
        if (ar_addr_log.size() == 4) begin
            check_output("basic addr0 literal", ar_addr_log[0], 33'h0_5000_0100);
            check_output("basic addr3 literal", ar_addr_log[3], 33'h0_5000_3100);
            check_output("basic arlen literal", ar_len_log[0], 8'd31);
        end

        apply_stimulus(32'd8, 32'h40, 33'h2000, 16'd64, 50, 0, 0, -1, 1'b1);
        check_run("limit", 32'd8, 32'h40, 33'h2000, 16'd64, 1'b0);
        check_output("limit reached", max_outst, MAX_OUT);

        apply_stimulus(32'd2, 32'h800, 33'h10, 16'd256, 2, 0, 10, -1, 1'b0);
        check_run("stall", 32'd2, 32'h800, 33'h10, 16'd256, 1'b0);
        check_output("stall consumed", stall_left, 0);

        apply_stimulus(32'd3, 32'h100, 33'h0, 16'd128, 0, 1, 0, -1, 1'b0);
        check_run("toggle", 32'd3, 32'h100, 33'h0, 16'd128, 1'b0);

        apply_stimulus(32'd0, 32'h100, 33'h0, 16'd128, 0, 0, 0, -1, 1'b0);
        check_run("zero_ops", 32'd0, 32'h100, 33'h0, 16'd128, 1'b0);

        apply_stimulus(32'd4, 32'h1000, 33'h0, 16'd64, 3, 0, 0, 3, 1'b0);
        check_run("rresp", 32'd4, 32'h1000, 33'h0, 16'd64, 1'b1);
        repeat (5) @(negedge clk);
        #2;
        check_output("err sticky", err, 1'b1);

        apply_stimulus(32'd2, 32'h1000, 33'hFFFF000, 16'd32, 1, 0, 0, -1, 1'b0);
        check_run("wrap", 32'd2, 32'h1000, 33'hFFFF000, 16'd32, 1'b0);
        if (ar_addr_log.size() == 2) begin
            check_output("wrap addr0 literal", ar_addr_log[0], 33'h0_5FFF_F000);
            check_output("wrap addr1 literal", ar_addr_log[1], 33'h0_5000_0000);
        end

        @(negedge clk);
        #2;
        read_ops       = 32'd8;
        stride         = 32'h100;
        init_addr      = 33'h400;
        mem_burst_size = 16'd64;
        r_delay        = 50;
        rdy_mode       = 0;
        stall_left     = 0;
        err_burst      = 0;
        start_read     = 1'b1;
        @(negedge clk);
        #2;
        start_read = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        check_output("midrst busy before", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check_output("midrst arvalid", m_axi_ARVALID, 1'b0);
        check_output("midrst araddr", m_axi_ARADDR, '0);
        check_output("midrst busy", busy, 1'b0);
        check_output("midrst done", done, 1'b0);
        check_output("midrst err", err, 1'b0);
        repeat (3) @(negedge clk);
        #2;
        check_output("midrst dn_vld", dn_vld, 1'b0);
        rst_n = 1'b1;

        apply_stimulus(32'd1, 32'h0, 33'h0, 16'd16, 0, 0, 0, -1, 1'b0);
        check_run("clamp_low", 32'd1, 32'h0, 33'h0, 16'd16, 1'b0);
        apply_stimulus(32'd2, 32'h100, 33'h0, 16'd20000, 0, 2, 0, -1, 1'b0);
        check_run("clamp_high", 32'd2, 32'h100, 33'h0, 16'd20000, 1'b0);

        for (int t = 0; t < 4; t++) begin
            r_ops  = 32'($urandom_range(1, 5));
            r_str  = $urandom;
            r_base = {1'b1, 4'hA, 28'($urandom)};
            r_size = 16'($urandom_range(0, 10000));
            apply_stimulus(r_ops, r_str, r_base, r_size, int'($urandom_range(0, 20)), 2, 0, -1, 1'b0);
            check_run($sformatf("rand%0d", t), r_ops, r_str, r_base, r_size, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
